// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Requester, memory and status bundle for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;

    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_ack;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;

    logic [DATA_W-1:0] rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        grant_id;
    logic              busy;

    modport slave (
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_addr, ls_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output if_ack, ls_ack, dbg_ack, rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output grant_id, busy
    );

    modport master (
        output if_req, if_addr,
        output ls_req, ls_we, ls_addr, ls_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  if_ack, ls_ack, dbg_ack, rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  grant_id, busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Fixed-priority (DBG > LS > IF) single-port memory arbiter
//               with an IF anti-starvation override.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input wire logic          clk,
    input wire logic          reset,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [LAT_W-1:0] c_LAT_INIT   = LAT_W'(MEM_LATENCY - 1);
    localparam logic [STV_W-1:0] c_STARVE_MAX = STV_W'(STARVE_LIMIT);
    localparam logic [1:0]       c_GID_NONE   = 2'd0;
    localparam logic [1:0]       c_GID_IF     = 2'd1;
    localparam logic [1:0]       c_GID_LS     = 2'd2;
    localparam logic [1:0]       c_GID_DBG    = 2'd3;

    state_t            r_state,     w_state_nxt;
    logic [LAT_W-1:0]  r_lat_cnt,   w_lat_cnt_nxt;
    logic [STV_W-1:0]  r_starve,    w_starve_nxt;
    logic [1:0]        r_grant,     w_grant_nxt;
    logic              r_mem_en,    w_mem_en_nxt;
    logic              r_mem_we,    w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [DATA_W-1:0] r_rdata,     w_rdata_nxt;
    logic              r_if_ack,    w_if_ack_nxt;
    logic              r_ls_ack,    w_ls_ack_nxt;
    logic              r_dbg_ack,   w_dbg_ack_nxt;
    logic [1:0]        w_winner;

    // A starved fetch overrides the fixed priority order.
    always_comb begin
        w_winner = c_GID_NONE;
        if (bus.if_req && (r_starve == c_STARVE_MAX)) begin
            w_winner = c_GID_IF;
        end else if (bus.dbg_req) begin
            w_winner = c_GID_DBG;
        end else if (bus.ls_req) begin
            w_winner = c_GID_LS;
        end else if (bus.if_req) begin
            w_winner = c_GID_IF;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_lat_cnt_nxt   = r_lat_cnt;
        w_starve_nxt    = r_starve;
        w_grant_nxt     = r_grant;
        w_mem_en_nxt    = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_rdata_nxt     = r_rdata;
        w_if_ack_nxt    = 1'b0;
        w_ls_ack_nxt    = 1'b0;
        w_dbg_ack_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!bus.if_req) begin
                    w_starve_nxt = '0;
                end
                if (w_winner != c_GID_NONE) begin
                    w_state_nxt   = S_ACCESS;
                    w_lat_cnt_nxt = c_LAT_INIT;
                    w_grant_nxt   = w_winner;
                    w_mem_en_nxt  = 1'b1;
                    if (w_winner == c_GID_IF) begin
                        w_starve_nxt = '0;
                    end else if (bus.if_req && (r_starve != c_STARVE_MAX)) begin
                        w_starve_nxt = r_starve + 1'b1;
                    end
                    case (w_winner)
                        c_GID_DBG: begin
                            w_mem_addr_nxt  = bus.dbg_addr;
                            w_mem_wdata_nxt = bus.dbg_wdata;
                            w_mem_we_nxt    = bus.dbg_we;
                        end
                        c_GID_LS: begin
                            w_mem_addr_nxt  = bus.ls_addr;
                            w_mem_wdata_nxt = bus.ls_wdata;
                            w_mem_we_nxt    = bus.ls_we;
                        end
                        default: begin
                            w_mem_addr_nxt  = bus.if_addr;
                            w_mem_wdata_nxt = '0;
                            w_mem_we_nxt    = 1'b0;
                        end
                    endcase
                end
            end
            S_ACCESS: begin
                // Counter hits zero in the last access cycle, when read data is valid.
                if (r_lat_cnt == '0) begin
                    w_state_nxt   = S_ACK;
                    w_rdata_nxt   = bus.mem_rdata;
                    w_if_ack_nxt  = (r_grant == c_GID_IF);
                    w_ls_ack_nxt  = (r_grant == c_GID_LS);
                    w_dbg_ack_nxt = (r_grant == c_GID_DBG);
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt - 1'b1;
                    w_mem_en_nxt  = 1'b1;
                end
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_lat_cnt   <= '0;
            r_starve    <= '0;
            r_grant     <= c_GID_NONE;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_if_ack    <= 1'b0;
            r_ls_ack    <= 1'b0;
            r_dbg_ack   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lat_cnt   <= w_lat_cnt_nxt;
            r_starve    <= w_starve_nxt;
            r_grant     <= w_grant_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_rdata     <= w_rdata_nxt;
            r_if_ack    <= w_if_ack_nxt;
            r_ls_ack    <= w_ls_ack_nxt;
            r_dbg_ack   <= w_dbg_ack_nxt;
        end
    end

    assign bus.if_ack    = r_if_ack;
    assign bus.ls_ack    = r_ls_ack;
    assign bus.dbg_ack   = r_dbg_ack;
    assign bus.rdata     = r_rdata;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.grant_id  = r_grant;
    assign bus.busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter with a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int L   = 3;
    localparam int LIM = 4;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L), .STARVE_LIMIT(LIM)) u_dut (
        .clk(clk), .reset(reset), .bus(bus3)
    );
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(LIM)) u_dut_l1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        return 32'hC0DE_0000 + 32'(i * 32'h111);
    endfunction

    // Memory for the latency-3 instance: data is only valid in the last enable cycle.
    logic [31:0] phys [16];
    logic [3:0]  en_run;
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) phys[i] <= init_word(i);
            en_run <= 4'd0;
        end else begin
            en_run <= bus3.mem_en ? en_run + 4'd1 : 4'd0;
            if (bus3.mem_en && bus3.mem_we) phys[bus3.mem_addr[5:2]] <= bus3.mem_wdata;
        end
    end
    assign bus3.mem_rdata = (bus3.mem_en && en_run == 4'(L - 1)) ? phys[bus3.mem_addr[5:2]]
                                                                 : (32'hBAD0_0000 | 32'(en_run));
    assign bus1.mem_rdata = bus1.mem_en ? 32'hE1A0_0000 : 32'h0BAD_BAD0;

    // Reference model state (transaction level, latency-3 instance only).
    bit          m_idle;
    int          m_k;
    int          m_starve;
    logic [1:0]  m_grant;
    logic [31:0] m_addr, m_wd, m_rdata;
    logic        m_we;
    logic [31:0] ref_mem [16];

    task automatic model_step();
        logic [1:0] w;
        if (reset) begin
            m_idle = 1'b1; m_k = 0; m_grant = 2'd0; m_starve = 0;
            for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
            return;
        end
        if (!m_idle) begin
            m_k++;
            if (m_k == L + 2) begin m_idle = 1'b1; m_k = 0; end
            return;
        end
        if (!bus3.if_req) m_starve = 0;
        if (!(bus3.if_req || bus3.ls_req || bus3.dbg_req)) return;
        if (bus3.if_req && m_starve == LIM) w = 2'd1;
        else if (bus3.dbg_req)              w = 2'd3;
        else if (bus3.ls_req)               w = 2'd2;
        else                                w = 2'd1;
        if (w == 2'd1)        m_starve = 0;
        else if (bus3.if_req) m_starve = (m_starve >= LIM) ? LIM : m_starve + 1;
        m_grant = w; m_idle = 1'b0; m_k = 1;
        case (w)
            2'd3:    begin m_addr = bus3.dbg_addr; m_we = bus3.dbg_we; m_wd = bus3.dbg_wdata; end
            2'd2:    begin m_addr = bus3.ls_addr;  m_we = bus3.ls_we;  m_wd = bus3.ls_wdata;  end
            default: begin m_addr = bus3.if_addr;  m_we = 1'b0;        m_wd = 32'd0;          end
        endcase
        if (m_we) ref_mem[m_addr[5:2]] = m_wd;
        else      m_rdata = ref_mem[m_addr[5:2]];
    endtask

    // {busy, mem_en, mem_we, if_ack, ls_ack, dbg_ack, grant_id} expected this cycle.
    function automatic logic [8:0] exp_ctrl();
        logic a;
        a = !m_idle && (m_k == L + 1);
        return {!m_idle, !m_idle && (m_k <= L), !m_idle && (m_k == 1) && m_we,
                a && (m_grant == 2'd1), a && (m_grant == 2'd2), a && (m_grant == 2'd3), m_grant};
    endfunction

    function automatic logic [8:0] act_ctrl();
        return {bus3.busy, bus3.mem_en, bus3.mem_we, bus3.if_ack, bus3.ls_ack, bus3.dbg_ack, bus3.grant_id};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus3.if_req = 1'b1; bus3.ls_req = 1'b1; bus3.dbg_req = 1'b1;
        bus3.if_addr = 32'h4; bus3.ls_addr = 32'h8; bus3.dbg_addr = 32'hC;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_vec++;
            if (act_ctrl() !== 9'd0 || bus3.rdata !== 32'd0 || bus3.mem_addr !== 32'd0
                || bus3.mem_wdata !== 32'd0) begin
                n_err++;
                $display("FAIL reset_state cyc%0d: ctrl=%b rdata=%h addr=%h wdata=%h, required all zero",
                         c, act_ctrl(), bus3.rdata, bus3.mem_addr, bus3.mem_wdata);
            end
        end
        reset = 1'b0;
        tick();
        n_vec++;
        if (bus3.grant_id !== 2'd3 || bus3.mem_en !== 1'b1) begin
            n_err++;
            $display("FAIL reset_first_grant: grant_id=%0d mem_en=%b, required 3/1", bus3.grant_id, bus3.mem_en);
        end
        bus3.if_req = 1'b0; bus3.ls_req = 1'b0; bus3.dbg_req = 1'b0;
        begin
            bit seen = 1'b0;
            for (int c = 0; c < 8 && !seen; c++) begin
                tick();
                if (bus3.dbg_ack) seen = 1'b1;
            end
            n_vec++;
            if (!seen) begin
                n_err++;
                $display("FAIL reset_dbg_ack: dbg_ack=0 after 8 cycles, required 1");
            end
        end
        tick(); tick();
    endtask

    task automatic test_latency1();
        bus1.if_req = 1'b1; bus1.if_addr = 32'h100;
        tick();
        n_vec++;
        if (bus1.mem_en !== 1'b1 || bus1.mem_we !== 1'b0 || bus1.mem_addr !== 32'h100 || bus1.if_ack !== 1'b0) begin
            n_err++;
            $display("FAIL lat1_access: en=%b we=%b addr=%h ack=%b, required 1/0/100/0",
                     bus1.mem_en, bus1.mem_we, bus1.mem_addr, bus1.if_ack);
        end
        tick();
        n_vec++;
        if (bus1.if_ack !== 1'b1 || bus1.mem_en !== 1'b0 || bus1.rdata !== 32'hE1A0_0000 || bus1.grant_id !== 2'd1) begin
            n_err++;
            $display("FAIL lat1_ack: ack=%b en=%b rdata=%h gid=%0d, required 1/0/e1a00000/1",
                     bus1.if_ack, bus1.mem_en, bus1.rdata, bus1.grant_id);
        end
        bus1.if_req = 1'b0;
        tick();
        n_vec++;
        if (bus1.if_ack !== 1'b0 || bus1.busy !== 1'b0 || bus1.grant_id !== 2'd1) begin
            n_err++;
            $display("FAIL lat1_after: ack=%b busy=%b gid=%0d, required 0/0/1", bus1.if_ack, bus1.busy, bus1.grant_id);
        end
        tick();
    endtask

    task automatic test_write_latency();
        int en_cnt = 0, we_cnt = 0, ack_at = 0;
        bus3.ls_req = 1'b1; bus3.ls_we = 1'b1; bus3.ls_addr = 32'h40; bus3.ls_wdata = 32'hDEAD_BEEF;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (bus3.mem_en) begin
                en_cnt++;
                n_vec++;
                if (bus3.mem_addr !== 32'h40 || bus3.mem_wdata !== 32'hDEAD_BEEF) begin
                    n_err++;
                    $display("FAIL wr_payload k%0d: addr=%h wdata=%h, required 40/deadbeef", k, bus3.mem_addr, bus3.mem_wdata);
                end
            end
            if (bus3.mem_we) we_cnt++;
            if (bus3.ls_ack) begin ack_at = k; bus3.ls_req = 1'b0; end
        end
        n_vec++;
        if (en_cnt != L || we_cnt != 1 || ack_at != L + 1) begin
            n_err++;
            $display("FAIL wr_timing: en_cycles=%0d we_cycles=%0d ack_cycle=%0d, required %0d/1/%0d",
                     en_cnt, we_cnt, ack_at, L, L + 1);
        end
        bus3.ls_we = 1'b0;
    endtask

    task automatic test_starvation();
        int losses = 0, grants = 0;
        logic [1:0] g, e;
        bus3.if_req = 1'b1; bus3.if_addr = 32'h20;
        bus3.ls_req = 1'b1; bus3.ls_we = 1'b0; bus3.ls_addr = 32'h24;
        for (int c = 0; c < 12 * (L + 2) && grants < 11; c++) begin
            tick();
            if (bus3.if_ack || bus3.ls_ack) begin
                g = bus3.if_ack ? 2'd1 : 2'd2;
                if (losses == LIM) begin e = 2'd1; losses = 0; end
                else               begin e = 2'd2; losses++;   end
                n_vec++;
                if (g !== e || (bus3.if_ack && bus3.ls_ack)) begin
                    n_err++;
                    $display("FAIL starve_order grant%0d: got %0d, required %0d", grants, g, e);
                end
                grants++;
                if (grants == 11) begin bus3.if_req = 1'b0; bus3.ls_req = 1'b0; end
            end
        end
        n_vec++;
        if (grants != 11) begin
            n_err++;
            $display("FAIL starve_count: %0d grants seen, required 11", grants);
        end
        bus3.if_req = 1'b0; bus3.ls_req = 1'b0;
        tick(); tick();
    endtask

    task automatic test_preempt();
        int ls_at = 0, dbg_at = 0;
        bus3.ls_req = 1'b1; bus3.ls_we = 1'b0; bus3.ls_addr = 32'h08;
        tick();
        bus3.dbg_req = 1'b1; bus3.dbg_we = 1'b0; bus3.dbg_addr = 32'h0C;
        for (int k = 2; k <= 14; k++) begin
            tick();
            if (bus3.ls_ack) begin
                ls_at = k; bus3.ls_req = 1'b0;
                n_vec++;
                if (bus3.rdata !== m_rdata) begin
                    n_err++;
                    $display("FAIL preempt_ls_rdata: rdata=%h, required %h", bus3.rdata, m_rdata);
                end
            end
            if (bus3.dbg_ack) begin
                dbg_at = k; bus3.dbg_req = 1'b0;
                n_vec++;
                if (bus3.rdata !== init_word(3) || bus3.grant_id !== 2'd3) begin
                    n_err++;
                    $display("FAIL preempt_dbg_rdata: rdata=%h gid=%0d, required %h/3",
                             bus3.rdata, bus3.grant_id, init_word(3));
                end
            end
        end
        n_vec++;
        if (ls_at != L + 1 || dbg_at != 2 * L + 3) begin
            n_err++;
            $display("FAIL preempt_order: ls_ack@%0d dbg_ack@%0d, required %0d/%0d", ls_at, dbg_at, L + 1, 2 * L + 3);
        end
    endtask

    task automatic test_reset_mid();
        int ack_at = 0;
        bus3.ls_req = 1'b1; bus3.ls_we = 1'b0; bus3.ls_addr = 32'h14;
        tick(); tick();
        reset = 1'b1;
        tick();
        n_vec++;
        if (act_ctrl() !== 9'd0) begin
            n_err++;
            $display("FAIL reset_mid_state: ctrl=%b, required 000000000", act_ctrl());
        end
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (bus3.ls_ack) begin
                ack_at = k; bus3.ls_req = 1'b0;
                n_vec++;
                if (bus3.rdata !== init_word(5)) begin
                    n_err++;
                    $display("FAIL reset_mid_rdata: rdata=%h, required %h", bus3.rdata, init_word(5));
                end
            end
        end
        n_vec++;
        if (ack_at != L + 1) begin
            n_err++;
            $display("FAIL reset_mid_retry: ls_ack@%0d, required %0d", ack_at, L + 1);
        end
    endtask

    task automatic test_random();
        bit ackm;
        for (int c = 0; c < 460; c++) begin
            tick();
            n_vec++;
            if (act_ctrl() !== exp_ctrl()) begin
                n_err++;
                $display("FAIL rand_ctrl cyc%0d: ctrl=%b, required %b", c, act_ctrl(), exp_ctrl());
            end
            ackm = !m_idle && (m_k == L + 1);
            if (!m_idle && m_k <= L) begin
                n_vec++;
                if (bus3.mem_addr !== m_addr || (m_we && bus3.mem_wdata !== m_wd)) begin
                    n_err++;
                    $display("FAIL rand_payload cyc%0d: addr=%h wdata=%h, required %h/%h",
                             c, bus3.mem_addr, bus3.mem_wdata, m_addr, m_wd);
                end
            end
            if (ackm && !m_we) begin
                n_vec++;
                if (bus3.rdata !== m_rdata) begin
                    n_err++;
                    $display("FAIL rand_rdata cyc%0d: rdata=%h, required %h", c, bus3.rdata, m_rdata);
                end
            end
            // Owners drop req on their ack; new requests stop in the final stretch.
            if (ackm && m_grant == 2'd1) bus3.if_req = 1'b0;
            else if (!bus3.if_req && c < 400 && $urandom_range(0, 3) == 0) begin
                bus3.if_req = 1'b1; bus3.if_addr = 32'($urandom_range(0, 15)) << 2;
            end
            if (ackm && m_grant == 2'd2) bus3.ls_req = 1'b0;
            else if (!bus3.ls_req && c < 400 && $urandom_range(0, 3) == 0) begin
                bus3.ls_req = 1'b1; bus3.ls_we = 1'($urandom_range(0, 1));
                bus3.ls_addr = 32'($urandom_range(0, 15)) << 2; bus3.ls_wdata = $urandom;
            end
            if (ackm && m_grant == 2'd3) bus3.dbg_req = 1'b0;
            else if (!bus3.dbg_req && c < 400 && $urandom_range(0, 9) == 0) begin
                bus3.dbg_req = 1'b1; bus3.dbg_we = 1'($urandom_range(0, 1));
                bus3.dbg_addr = 32'($urandom_range(0, 15)) << 2; bus3.dbg_wdata = $urandom;
            end
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b1;
        bus3.if_req = 1'b0; bus3.if_addr = '0;
        bus3.ls_req = 1'b0; bus3.ls_we = 1'b0; bus3.ls_addr = '0; bus3.ls_wdata = '0;
        bus3.dbg_req = 1'b0; bus3.dbg_we = 1'b0; bus3.dbg_addr = '0; bus3.dbg_wdata = '0;
        bus1.if_req = 1'b0; bus1.if_addr = '0;
        bus1.ls_req = 1'b0; bus1.ls_we = 1'b0; bus1.ls_addr = '0; bus1.ls_wdata = '0;
        bus1.dbg_req = 1'b0; bus1.dbg_we = 1'b0; bus1.dbg_addr = '0; bus1.dbg_wdata = '0;
        m_idle = 1'b1; m_k = 0; m_starve = 0; m_grant = 2'd0;
        m_addr = '0; m_wd = '0; m_rdata = '0; m_we = 1'b0;
        test_reset();
        test_latency1();
        test_write_latency();
        test_starvation();
        test_preempt();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
